// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sync/pixel pipeline:
// output mode encodings, the 24-bit pixel type and the colour-bar table.
package vga_pkg;

    typedef logic [23:0] rgb24;

    typedef enum logic [1:0] {
        MODE_CAM   = 2'd0,
        MODE_OVL   = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam rgb24 BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/sync_window_decode.sv
// Inclusive scan-count window decode with optional wrap (START > END),
// driving a sync level of the configured polarity.
module sync_window_decode #(
    parameter int unsigned CW    = 13,
    parameter int unsigned START = 0,
    parameter int unsigned END   = 0,
    parameter bit          POL   = 1'b0
) (
    input  logic [CW-1:0] cnt,
    output logic          level
);

    localparam logic [CW-1:0] START_C = CW'(START);
    localparam logic [CW-1:0] END_C   = CW'(END);

    logic in_win;

    always_comb begin
        if (START_C <= END_C) begin
            in_win = (cnt >= START_C) && (cnt <= END_C);
        end else begin
            in_win = (cnt >= START_C) || (cnt <= END_C);
        end
        level = in_win ? POL : ~POL;
    end

endmodule

// File: rtl/vga_sync_pipeline.sv
// Registered VGA sync/blank/RGB generation from camera scan counters, with a
// per-frame latched output mode, frame counter and delay-matched pipeline.
module vga_sync_pipeline
    import vga_pkg::*;
#(
    parameter int unsigned CW         = 13,
    parameter int unsigned HS_START   = 2,
    parameter int unsigned HS_END     = 97,
    parameter int unsigned VS_START   = 12,
    parameter int unsigned VS_END     = 13,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned BAR_SHIFT  = 7,
    parameter int unsigned FCW        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    input  logic           cam_valid,
    input  logic [CW-1:0]  cam_xcont,
    input  logic [CW-1:0]  cam_ycont,
    input  logic [1:0]     mode,
    input  logic [23:0]    solid_rgb,
    input  logic [23:0]    cam_rgb,
    input  logic           ovl_en,
    input  logic [23:0]    ovl_rgb,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic [FCW-1:0] frame_count,
    output logic           frame_start
);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        rgb24 rgb;
    } stage_t;

    localparam int unsigned SW = $bits(stage_t);
    localparam int unsigned PW = PIPE_DEPTH * SW;
    localparam stage_t STAGE_RST = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0, rgb: '0};

    logic           hs_lvl, vs_lvl, hs_act, vs_act, vs_rise;
    logic           vs_act_q, vs_act_d;
    mode_e          mode_q, mode_d, mode_eff;
    logic [FCW-1:0] frame_count_q, frame_count_d;
    logic           frame_start_q, frame_start_d;
    logic [PW-1:0]  pipe_q, pipe_d;
    logic [CW-1:0]  bar_full;
    logic [2:0]     bar_idx;
    rgb24           pix_rgb;
    stage_t         stage_in, stage_out;

    sync_window_decode #(.CW(CW), .START(HS_START), .END(HS_END), .POL(HS_POL)) u_hs_dec (
        .cnt   (cam_xcont),
        .level (hs_lvl)
    );

    sync_window_decode #(.CW(CW), .START(VS_START), .END(VS_END), .POL(VS_POL)) u_vs_dec (
        .cnt   (cam_ycont),
        .level (vs_lvl)
    );

    assign hs_act  = (hs_lvl == HS_POL);
    assign vs_act  = (vs_lvl == VS_POL);
    assign vs_rise = pix_en && vs_act && !vs_act_q;

    // The frame that starts on this pixel already uses the newly sampled mode.
    always_comb begin
        mode_eff = vs_rise ? mode_e'(mode) : mode_q;
        bar_full = cam_xcont >> BAR_SHIFT;
        bar_idx  = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
        pix_rgb  = '0;
        if (cam_valid) begin
            case (mode_eff)
                MODE_CAM:  pix_rgb = cam_rgb;
                MODE_OVL:  pix_rgb = ovl_en ? ovl_rgb : cam_rgb;
                MODE_BARS: pix_rgb = BAR_COLORS[bar_idx];
                default:   pix_rgb = solid_rgb;
            endcase
        end
        stage_in = '{hs: hs_lvl, vs: vs_lvl, blank_n: !hs_act && !vs_act && cam_valid,
                     rgb: pix_rgb};
    end

    always_comb begin
        vs_act_d      = vs_act_q;
        mode_d        = mode_q;
        frame_count_d = frame_count_q;
        frame_start_d = vs_rise;
        pipe_d        = pipe_q;
        if (pix_en) begin
            vs_act_d = vs_act;
            // Newest stage in the low slot; the oldest falls off the top.
            pipe_d   = PW'({pipe_q, stage_in});
        end
        if (vs_rise) begin
            mode_d        = mode_e'(mode);
            frame_count_d = frame_count_q + FCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_act_q      <= 1'b0;
            mode_q        <= MODE_CAM;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
            pipe_q        <= {PIPE_DEPTH{STAGE_RST}};
        end else begin
            vs_act_q      <= vs_act_d;
            mode_q        <= mode_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
            pipe_q        <= pipe_d;
        end
    end

    assign stage_out   = pipe_q[PW-1 -: SW];
    assign VGA_HS      = stage_out.hs;
    assign VGA_VS      = stage_out.vs;
    assign VGA_BLANK_N = stage_out.blank_n;
    assign VGA_R       = stage_out.rgb[23:16];
    assign VGA_G       = stage_out.rgb[15:8];
    assign VGA_B       = stage_out.rgb[7:0];
    assign frame_count = frame_count_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_pipeline.md
Name: vga_sync_pipeline

Overview:
Parametrised successor to the fixed-constant VGA sync/pixel-select logic in the D8M camera top level. It takes camera scan counters and pixel data and produces registered VGA HS/VS/BLANK_N and RGB. Sync windows, polarity and pipeline depth are configurable, and the HS/VS window may wrap around. It adds a frame counter and a frame-start strobe, a mode select latched once per frame (camera, camera plus overlay, colour bars, solid fill), and delay matching between the sync and pixel paths. It sits between camera_out/collisionDemo and the VGA pins.

Parameters:
CW, 13, width of cam_xcont/cam_ycont
HS_START, 2, first x count of HS pulse
HS_END, 97, last x count of HS pulse (inclusive)
VS_START, 12, first y count of VS pulse
VS_END, 13, last y count of VS pulse (inclusive)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
PIPE_DEPTH, 2, pix_en-qualified stages from input to output; minimum 1
BAR_SHIFT, 7, colour-bar width is 2^BAR_SHIFT pixels
FCW, 16, frame_count width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
pix_en  in  1  pixel-rate clock enable; all pipeline state advances only when high
cam_valid  in  1  active-video qualifier
cam_xcont  in  CW  horizontal scan count
cam_ycont  in  CW  vertical scan count
mode  in  2  0 camera, 1 camera+overlay, 2 colour bars, 3 solid fill
solid_rgb  in  24  fill colour {R,G,B} for mode 3
cam_rgb  in  24  camera pixel {R,G,B}
ovl_en  in  1  overlay pixel valid (used in mode 1 only)
ovl_rgb  in  24  overlay pixel
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_BLANK_N  out  1  high during active video
VGA_R/VGA_G/VGA_B  out  8 each  pixel colour
frame_count  out  FCW  completed-frame counter
frame_start  out  1  one-clk pulse per frame

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, VGA_BLANK_N = 0, RGB = 0, frame_count = 0, frame_start = 0, latched mode = 0. All pipeline stages are cleared to the same inactive values.
- Reset takes priority over pix_en. A reset mid-frame clears the pipeline. The first valid output appears PIPE_DEPTH pix_en cycles after reset is released.
- Window decode, inclusive:
  - If START <= END: in_win = (cnt >= START) && (cnt <= END).
  - If START > END (wrap): in_win = (cnt >= START) || (cnt <= END).
  - If START == END: single-count pulse.
- Sync level: hs = in_win_h ? HS_POL : ~HS_POL. VS is decoded the same way.
- BLANK_N: registered with the same latency as sync, from the sync-inactive state ANDed with cam_valid.
- Latency: sync, blank and RGB all leave exactly PIPE_DEPTH pix_en cycles after their inputs are sampled, so all outputs stay mutually aligned.
- pix_en low: every stage and every output holds its value. frame_start is excepted: it still pulses for only one clk.
- Mode latch: mode is sampled into mode_q on the stage-1 cycle where decoded VS transitions inactive→active (frame boundary). A mode change mid-frame never alters the current frame.
- frame_start: pulses high for one clk on that same transition.
- frame_count: increments by 1 on that same transition and wraps from 2^FCW-1 to 0.
- Pixel select (stage 1), when cam_valid = 1:
  - mode 0: cam_rgb.
  - mode 1: ovl_rgb if ovl_en, else cam_rgb.
  - mode 2: bar = cam_xcont >> BAR_SHIFT, saturated at 7. Bar colours 0..7 are white, yellow, cyan, green, magenta, red, blue, black, with component values 0xFF/0x00.
  - mode 3: solid_rgb.
- Pixel select when cam_valid = 0: RGB = 0 in every mode.
- Simultaneous mode change and VS start: the new mode is captured and applies to the frame that begins.
- Counter wrap (cam_xcont → 0): no special handling; decode is purely combinational on the current counts.

Decomposition:
- Shared package vga_pkg holds:
  - mode encodings MODE_CAM/MODE_OVL/MODE_BARS/MODE_SOLID;
  - the 8-entry bar colour constant table;
  - the rgb24 typedef.
- Sub-module sync_window_decode: parameters CW, START, END, POL; input cnt; output level. Instantiated twice (H and V).
- Delay matching is a generic shift register inside this block.

Test Plan:
- Defaults, pix_en = 1: sweep x 0..799 → VGA_HS low exactly for x = 2..97 seen 2 cycles later. VGA_VS low for y = 12..13. Reset values hold while reset = 1.
- HS_START = 790, HS_END = 5 (wrap): x = 789 → HS high; x = 790..799 and 0..5 → low; x = 6 → high.
- Mode 2, BAR_SHIFT = 7, cam_valid = 1: x = 0 → FFFFFF; x = 130 → FFFF00; x = 900 → 000000 (saturated bar 7). cam_valid = 0 → 000000.
- Mode switched 0→3 mid-frame (solid_rgb = 123456): output stays cam_rgb until the next VS assertion. frame_start pulses once there, frame_count goes 0→1, and subsequent active pixels = 123456.
- pix_en toggled 1-in-2: outputs change only on enabled cycles and latency stays 2 enabled cycles. Reset asserted mid-line: next clk all outputs are at reset values.
- frame_count with FCW = 2: 5 frames → 1,2,3,0,1.
